// File: rtl/k005290_sequencer.sv
// Per-pixel controller for the tilemap shift-register array.
// Turns the absolute hcounter, per-layer fine X scroll, tile flip attributes
// and layer enables into the A/B shift-register mode and flip-select signals.
// Each 8-pixel tile line is loaded once per tile at the scroll-adjusted phase.

module k005290_sequencer #(
    parameter logic [8:0] ACT_START  = 9'd136,
    parameter logic [8:0] ACT_END    = 9'd392,
    parameter logic [8:0] LINE_LATCH = 9'd128
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_RST_n,
    input  logic       i_EMU_CLK6MPCEN_n,
    input  logic [8:0] i_HCNT,
    input  logic [2:0] i_A_FINE,
    input  logic [2:0] i_B_FINE,
    input  logic       i_A_TILEFLIP,
    input  logic       i_B_TILEFLIP,
    input  logic       i_A_EN,
    input  logic       i_B_EN,
    output logic [1:0] o_A_MODE,
    output logic [1:0] o_B_MODE,
    output logic       o_AFF,
    output logic       o_BFF,
    output logic       o_A_ACTIVE,
    output logic       o_B_ACTIVE
);

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeRight = 2'b01;
    localparam logic [1:0] ModeLeft  = 2'b10;
    localparam logic [1:0] ModeLoad  = 2'b11;

    localparam logic [8:0] ArmHcnt = ACT_START - 9'd1;
    localparam logic [8:0] EndHcnt = ACT_END - 9'd1;

    // StDis: layer disabled for this line, shifts zeros through the whole window.
    typedef enum logic [2:0] {StBlank, StArm, StRun, StFlush, StDis} state_e;

    // Index 0 is layer A, index 1 is layer B.
    logic       ce;
    logic       latch_hit;
    logic [2:0] fine_in  [2];
    logic       en_in    [2];
    logic       tflip_in [2];
    logic [2:0] fine_eff [2];
    logic       en_eff   [2];
    logic [2:0] ld_tgt   [2];
    logic       ld       [2];
    logic [1:0] mode     [2];

    logic [2:0] fine_q [2], fine_d [2];
    logic       en_q   [2], en_d   [2];
    state_e     state_q[2], state_d[2];
    logic [2:0] cnt_q  [2], cnt_d  [2];
    // Flip held for the tile currently in the array; doubles as the XFF output.
    logic       flip_q [2], flip_d [2];

    assign ce        = ~i_EMU_CLK6MPCEN_n;
    assign latch_hit = (i_HCNT == LINE_LATCH);

    // Gather per-layer inputs and decode the load phase.
    always_comb begin
        fine_in[0]  = i_A_FINE;
        fine_in[1]  = i_B_FINE;
        en_in[0]    = i_A_EN;
        en_in[1]    = i_B_EN;
        tflip_in[0] = i_A_TILEFLIP;
        tflip_in[1] = i_B_TILEFLIP;
        for (int x = 0; x < 2; x++) begin
            // A mis-placed latch point makes new scroll values apply at once.
            fine_eff[x] = latch_hit ? fine_in[x] : fine_q[x];
            en_eff[x]   = latch_hit ? en_in[x] : en_q[x];
            // Layer B latches half a tile later than layer A.
            ld_tgt[x]   = fine_eff[x] + ((x == 1) ? 3'd4 : 3'd0);
            ld[x]       = (i_HCNT[2:0] == ld_tgt[x]);
        end
    end

    // Line configuration capture next-state.
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            fine_d[x] = fine_q[x];
            en_d[x]   = en_q[x];
            if (ce && latch_hit) begin
                fine_d[x] = fine_in[x];
                en_d[x]   = en_in[x];
            end
        end
    end

    // Line configuration registers.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            for (int x = 0; x < 2; x++) begin
                fine_q[x] <= 3'd0;
                en_q[x]   <= 1'b0;
            end
        end else begin
            for (int x = 0; x < 2; x++) begin
                fine_q[x] <= fine_d[x];
                en_q[x]   <= en_d[x];
            end
        end
    end

    // Per-layer FSM next-state, flush counter and flip capture.
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            state_d[x] = state_q[x];
            cnt_d[x]   = cnt_q[x];
            flip_d[x]  = flip_q[x];
            if (ce) begin
                unique case (state_q[x])
                    StBlank: begin
                        if (i_HCNT == ArmHcnt) begin
                            state_d[x] = en_eff[x] ? StArm : StDis;
                        end
                    end
                    StArm: begin
                        if (ld[x]) begin
                            state_d[x] = StRun;
                            flip_d[x]  = tflip_in[x];
                        end
                        if (i_HCNT == EndHcnt) begin
                            state_d[x] = StFlush;
                            cnt_d[x]   = 3'd7;
                        end
                    end
                    StRun: begin
                        if (ld[x]) begin
                            flip_d[x] = tflip_in[x];
                        end
                        // A load on the last active pixel still happens first.
                        if (i_HCNT == EndHcnt) begin
                            state_d[x] = StFlush;
                            cnt_d[x]   = 3'd7;
                        end
                    end
                    StDis: begin
                        if (i_HCNT == EndHcnt) begin
                            state_d[x] = StFlush;
                            cnt_d[x]   = 3'd7;
                        end
                    end
                    StFlush: begin
                        cnt_d[x] = cnt_q[x] - 3'd1;
                        if (cnt_q[x] == 3'd0) begin
                            state_d[x] = StBlank;
                        end
                    end
                    default: state_d[x] = StBlank;
                endcase
            end
        end
    end

    // Per-layer FSM state registers.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            for (int x = 0; x < 2; x++) begin
                state_q[x] <= StBlank;
                cnt_q[x]   <= 3'd0;
                flip_q[x]  <= 1'b0;
            end
        end else begin
            for (int x = 0; x < 2; x++) begin
                state_q[x] <= state_d[x];
                cnt_q[x]   <= cnt_d[x];
                flip_q[x]  <= flip_d[x];
            end
        end
    end

    // Mode outputs; combinational so the array sees them on the same edge.
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            mode[x] = ModeHold;
            unique case (state_q[x])
                StBlank: mode[x] = ModeHold;
                StArm:   mode[x] = ld[x] ? ModeLoad : ModeHold;
                StRun: begin
                    if (ld[x]) begin
                        mode[x] = ModeLoad;
                    end else begin
                        mode[x] = flip_q[x] ? ModeRight : ModeLeft;
                    end
                end
                StDis:   mode[x] = ModeLeft;
                StFlush: mode[x] = ModeLeft;
                default: mode[x] = ModeHold;
            endcase
        end
    end

    assign o_A_MODE   = mode[0];
    assign o_B_MODE   = mode[1];
    assign o_AFF      = flip_q[0];
    assign o_BFF      = flip_q[1];
    assign o_A_ACTIVE = (state_q[0] == StRun);
    assign o_B_ACTIVE = (state_q[1] == StRun);

endmodule

// File: tb/tb_k005290_sequencer.sv
// Randomised bench for k005290_sequencer against a line-window reference model.

module tb_k005290_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen_n;
    logic [8:0] hcnt;
    logic [2:0] a_fine, b_fine;
    logic       a_tflip, b_tflip, a_en, b_en;
    logic [1:0] a_mode, b_mode;
    logic       aff, bff, a_act, b_act;

    k005290_sequencer dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_RST_n       (rst_n),
        .i_EMU_CLK6MPCEN_n (cen_n),
        .i_HCNT            (hcnt),
        .i_A_FINE          (a_fine),
        .i_B_FINE          (b_fine),
        .i_A_TILEFLIP      (a_tflip),
        .i_B_TILEFLIP      (b_tflip),
        .i_A_EN            (a_en),
        .i_B_EN            (b_en),
        .o_A_MODE          (a_mode),
        .o_B_MODE          (b_mode),
        .o_AFF             (aff),
        .o_BFF             (bff),
        .o_A_ACTIVE        (a_act),
        .o_B_ACTIVE        (b_act)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each layer knows about the current line.
    bit         m_ok     [2];  // saw the arm point since the last reset
    bit         m_en     [2];
    bit         m_loaded [2];  // at least one tile loaded this line
    bit         m_flip   [2];
    logic [2:0] m_fine   [2];

    // Per-line stimulus configuration.
    logic [2:0] cfg_fine [2];
    bit         cfg_en   [2];
    int         cfg_fmode[2];  // 0 never flip, 1 alternate tiles, 2 random

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at hcnt %0d", tag, obs, exp, hcnt);
        end
    endtask

    function automatic logic [2:0] load_phase(int x);
        logic [2:0] p;
        p = m_fine[x];
        if (x == 1) p = p + 3'd4;
        return p;
    endfunction

    // Active window 136..391, then 8 flush pixels 392..399.
    function automatic logic [1:0] exp_mode(int x, logic [8:0] h);
        if (!m_ok[x] || h < 9'd136 || h > 9'd399) return 2'b00;
        if (h >= 9'd392) return 2'b10;
        if (!m_en[x]) return 2'b10;
        if (h[2:0] == load_phase(x)) return 2'b11;
        if (!m_loaded[x]) return 2'b00;
        return m_flip[x] ? 2'b01 : 2'b10;
    endfunction

    function automatic logic exp_active(int x, logic [8:0] h);
        return m_ok[x] && m_en[x] && m_loaded[x] && h >= 9'd136 && h <= 9'd391;
    endfunction

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            m_ok[x] = 0; m_en[x] = 0; m_loaded[x] = 0; m_flip[x] = 0; m_fine[x] = 3'd0;
        end
    endtask

    // Advance the model for one pixel clock enable with the current inputs.
    task automatic model_edge();
        logic [2:0] fi [2];
        bit         ei [2];
        bit         tf [2];
        fi[0] = a_fine;  fi[1] = b_fine;
        ei[0] = a_en;    ei[1] = b_en;
        tf[0] = a_tflip; tf[1] = b_tflip;
        for (int x = 0; x < 2; x++) begin
            if (hcnt == 9'd128) begin
                m_fine[x] = fi[x];
                m_en[x]   = ei[x];
            end
            if (hcnt == 9'd135) begin
                m_ok[x]     = 1;
                m_loaded[x] = 0;
            end
            if (m_ok[x] && m_en[x] && hcnt >= 9'd136 && hcnt <= 9'd391 &&
                hcnt[2:0] == load_phase(x)) begin
                m_loaded[x] = 1;
                m_flip[x]   = tf[x];
            end
        end
    endtask

    function automatic logic flip_val(int m);
        if (m == 0) return 1'b0;
        if (m == 1) return hcnt[3];
        return 1'($urandom_range(1));
    endfunction

    // Config is presented up to the capture point, junk afterwards.
    task automatic drive_inputs();
        if (hcnt <= 9'd128) begin
            a_fine = cfg_fine[0]; b_fine = cfg_fine[1];
            a_en   = cfg_en[0];   b_en   = cfg_en[1];
        end else begin
            a_fine = 3'($urandom_range(7)); b_fine = 3'($urandom_range(7));
            a_en   = 1'($urandom_range(1)); b_en   = 1'($urandom_range(1));
        end
        a_tflip = flip_val(cfg_fmode[0]);
        b_tflip = flip_val(cfg_fmode[1]);
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, "A_MODE"}, 32'(a_mode), 32'(exp_mode(0, hcnt)));
        check_eq({pfx, "B_MODE"}, 32'(b_mode), 32'(exp_mode(1, hcnt)));
        check_eq({pfx, "AFF"},    32'(aff),    32'(m_flip[0]));
        check_eq({pfx, "BFF"},    32'(bff),    32'(m_flip[1]));
        check_eq({pfx, "A_ACT"},  32'(a_act),  32'(exp_active(0, hcnt)));
        check_eq({pfx, "B_ACT"},  32'(b_act),  32'(exp_active(1, hcnt)));
    endtask

    task automatic cycle(input bit stall);
        cen_n = stall;
        @(negedge clk);
        check_outputs(stall ? "STALL_" : "");
        @(posedge clk);
        if (!stall) model_edge();
        #1;
        if (!stall) begin
            hcnt = hcnt + 9'd1;
            drive_inputs();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("MIDRST_A_MODE", 32'(a_mode), 32'd0);
        check_eq("MIDRST_B_MODE", 32'(b_mode), 32'd0);
        check_eq("MIDRST_AFF",    32'(aff),    32'd0);
        check_eq("MIDRST_BFF",    32'(bff),    32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_line(input int stall_pct, input bit stall_200, input bit rst_200);
        int  steps = 0;
        bit  stalled = 0;
        bit  did_rst = 0;
        bit  s;
        drive_inputs();
        while (steps < 512) begin
            if (rst_200 && !did_rst && hcnt == 9'd200) begin
                do_reset();
                did_rst = 1;
            end
            if (stall_200 && !stalled && hcnt == 9'd200) begin
                repeat (3) cycle(1'b1);
                stalled = 1;
            end
            s = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            cycle(s);
            if (!s) steps++;
        end
    endtask

    task automatic rand_cfg(input bit force_en);
        for (int x = 0; x < 2; x++) begin
            cfg_fine[x]  = 3'($urandom_range(7));
            cfg_en[x]    = force_en || ($urandom_range(3) != 0);
            cfg_fmode[x] = $urandom_range(2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL TIMEOUT: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cen_n = 1'b1; hcnt = 9'd0;
        a_fine = 3'd0; b_fine = 3'd0; a_tflip = 1'b0; b_tflip = 1'b0; a_en = 1'b0; b_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("RST_");
        rst_n = 1'b1;

        // Zero scroll, no flip.
        cfg_fine[0] = 3'd0; cfg_fine[1] = 3'd0; cfg_en[0] = 1; cfg_en[1] = 1;
        cfg_fmode[0] = 0; cfg_fmode[1] = 0;
        run_line(0, 0, 0);
        // Layer A scroll 5 with flip on alternate tiles.
        rand_cfg(1); cfg_fine[0] = 3'd5; cfg_fmode[0] = 1;
        run_line(0, 0, 0);
        // Layer A load on the phase-7 latch edge.
        rand_cfg(1); cfg_fine[0] = 3'd7;
        run_line(0, 0, 0);
        // Layer B disabled, A enabled.
        rand_cfg(1); cfg_en[1] = 0;
        run_line(0, 0, 0);
        // Pixel clock stall mid-line.
        rand_cfg(1);
        run_line(0, 1, 0);
        // Reset mid-line, then a normal line.
        rand_cfg(1);
        run_line(0, 0, 1);
        rand_cfg(1);
        run_line(0, 0, 0);
        // Fully random lines with random stalls.
        for (int l = 0; l < 8; l++) begin
            rand_cfg(0);
            run_line(15, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
